// File: rtl/sp_ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: clear FSM states and
// requester port indices.
package sp_ram_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int PORT0 = 0;
  localparam int PORT1 = 1;

endpackage : sp_ram_arb_pkg

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. rr_last remembers the most recently
// granted port; on contention the other port wins.
module rr_arb2
  import sp_ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic       rr_last_q;
  logic       rr_last_d;
  logic [1:0] grant_raw;

  always_comb begin
    grant_raw = 2'b00;
    case (req)
      2'b01:   grant_raw = 2'b01;
      2'b10:   grant_raw = 2'b10;
      2'b11:   grant_raw = (rr_last_q == 1'(PORT1)) ? 2'b01 : 2'b10;
      default: grant_raw = 2'b00;
    endcase
  end

  // No grant may leak out while the block is held in reset.
  assign grant = rst_n ? grant_raw : 2'b00;

  always_comb begin
    rr_last_d = rr_last_q;
    if (advance && (grant != 2'b00)) begin
      rr_last_d = grant[PORT1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= 1'(PORT1);
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule : rr_arb2

// File: rtl/sp_ram_arbiter.sv
// Shares one single-port registered-read RAM between two requesters with
// round-robin arbitration, plus a sweep engine that clears every word.
module sp_ram_arbiter
  import sp_ram_arb_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 36,
  parameter int                    ADDR_WIDTH  = 10,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done,

  input  logic                  p0_valid,
  output logic                  p0_ready,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,

  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,

  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d;
  logic                    done_q, done_d;
  logic                    p0_rvalid_q, p0_rvalid_d;
  logic                    p1_rvalid_q, p1_rvalid_d;

  logic                    arb_open;
  logic [1:0]              req;
  logic [1:0]              grant;
  logic                    advance;

  // A clear request steals the cycle: nothing is offered to the arbiter.
  assign arb_open = (state_q == ST_IDLE) && !clear_start;
  assign req      = arb_open ? {p1_valid, p0_valid} : 2'b00;
  assign advance  = |grant;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (advance),
    .grant   (grant)
  );

  assign p0_ready = grant[PORT0];
  assign p1_ready = grant[PORT1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    ram_wr_en = 1'b0;
    ram_addr  = addr_q;
    ram_din   = din_q;

    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (grant[PORT0]) begin
          ram_wr_en = p0_we;
          ram_addr  = p0_addr;
          ram_din   = p0_wdata;
        end else if (grant[PORT1]) begin
          ram_wr_en = p1_we;
          ram_addr  = p1_addr;
          ram_din   = p1_wdata;
        end
      end
      ST_CLEAR: begin
        ram_wr_en = 1'b1;
        ram_addr  = cnt_q;
        ram_din   = CLEAR_VALUE;
        cnt_d     = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Idle cycles keep presenting whatever the RAM saw last.
    addr_d = ram_addr;
    din_d  = ram_din;
  end

  assign p0_rvalid_d = grant[PORT0] && !p0_we;
  assign p1_rvalid_d = grant[PORT1] && !p1_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      done_q      <= 1'b0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      done_q      <= done_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
    end
  end

  assign clear_busy = (state_q == ST_CLEAR);
  assign clear_done = done_q;
  assign p0_rvalid  = p0_rvalid_q;
  assign p1_rvalid  = p1_rvalid_q;
  // Registered-read RAM: dout already lines up with the rvalid pulse.
  assign p0_rdata   = ram_dout;
  assign p1_rdata   = ram_dout;

endmodule : sp_ram_arbiter

// File: tb/tb_sp_ram_arbiter.sv
// Scoreboard bench for sp_ram_arbiter on a 16-word RAM: a cycle-level
// reference model predicts grants, RAM drive, clear sweep and read data.
module tb_sp_ram_arbiter;

  localparam int DW   = 36;
  localparam int AW   = 4;
  localparam int MSZ  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear_start = 1'b0;
  logic          clear_busy, clear_done;
  logic          p0_valid = 1'b0, p0_we = 1'b0, p1_valid = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic          p0_ready, p1_ready, p0_rvalid, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          ram_wr_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;

  always #5 clk = ~clk;

  sp_ram_arbiter #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .CLEAR_VALUE ('0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .p0_valid    (p0_valid),
    .p0_ready    (p0_ready),
    .p0_we       (p0_we),
    .p0_addr     (p0_addr),
    .p0_wdata    (p0_wdata),
    .p0_rvalid   (p0_rvalid),
    .p0_rdata    (p0_rdata),
    .p1_valid    (p1_valid),
    .p1_ready    (p1_ready),
    .p1_we       (p1_we),
    .p1_addr     (p1_addr),
    .p1_wdata    (p1_wdata),
    .p1_rvalid   (p1_rvalid),
    .p1_rdata    (p1_rdata),
    .ram_wr_en   (ram_wr_en),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_dout    (ram_dout)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 5) return 36'h123456789;
    return 36'hF00000001 + 36'(i) * 36'h000111111;
  endfunction

  // Single-port RAM with registered read, loaded with a known image.
  logic [DW-1:0] ram [MSZ];
  bit            ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < MSZ; i++) ram[i] <= init_val(i);
      ram_loaded <= 1'b1;
    end else begin
      if (ram_wr_en) ram[ram_addr] <= ram_din;
      ram_dout <= ram[ram_addr];
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  // Reference model state
  logic [DW-1:0] m_mem [MSZ];
  int            m_clear_left = 0;
  bit            m_done_next = 1'b0;
  int            m_rr = 1;
  int            m_win = -1;

  task automatic mon_port(input int p, input logic rv, input logic [DW-1:0] rd);
    exp_t e;
    bit   due;
    due = 1'b0;
    if (p == 0) begin
      if (q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); due = 1'b1; end
    end else begin
      if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); due = 1'b1; end
    end
    if (due) begin
      chk($sformatf("p%0d_rvalid", p), 64'(rv), 64'(1));
      chk($sformatf("p%0d_rdata", p), 64'(rd), 64'(e.data));
      $display("read p%0d data=%0h expected=%0h", p, rd, e.data);
    end else begin
      chk($sformatf("p%0d_rvalid_spurious", p), 64'(rv), 64'(0));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon_port(0, p0_rvalid, p0_rdata);
      mon_port(1, p1_rvalid, p1_rdata);
    end
  end

  // One cycle: drive, predict, compare, then advance the model.
  task automatic step(input bit v0, input bit w0, input int a0, input logic [DW-1:0] d0,
                      input bit v1, input bit w1, input int a1, input logic [DW-1:0] d1,
                      input bit cs);
    int caddr;
    int win;
    bit ww;
    int wa;
    logic [DW-1:0] wd;
    @(negedge clk);
    p0_valid = v0; p0_we = w0; p0_addr = AW'(a0); p0_wdata = d0;
    p1_valid = v1; p1_we = w1; p1_addr = AW'(a1); p1_wdata = d1;
    clear_start = cs;
    #1;
    win = -1;
    caddr = 0;
    ww = 1'b0; wa = 0; wd = '0;
    if (m_clear_left > 0) begin
      caddr = MSZ - m_clear_left;
      chk("clr_busy", 64'(clear_busy), 64'(1));
      chk("clr_wr_en", 64'(ram_wr_en), 64'(1));
      chk("clr_addr", 64'(ram_addr), 64'(caddr));
      chk("clr_din", 64'(ram_din), 64'(0));
    end else begin
      chk("busy_idle", 64'(clear_busy), 64'(0));
      if (!cs) begin
        if (v0 && v1) win = (m_rr == 1) ? 0 : 1;
        else if (v0)  win = 0;
        else if (v1)  win = 1;
      end
      if (win == 0) begin ww = w0; wa = a0; wd = d0; end
      if (win == 1) begin ww = w1; wa = a1; wd = d1; end
      chk("wr_en", 64'(ram_wr_en), 64'(ww));
      if (win >= 0) begin
        chk("grant_addr", 64'(ram_addr), 64'(wa));
        if (ww) chk("grant_din", 64'(ram_din), 64'(wd));
      end
    end
    chk("p0_ready", 64'(p0_ready), 64'(win == 0));
    chk("p1_ready", 64'(p1_ready), 64'(win == 1));
    chk("clear_done", 64'(clear_done), 64'(m_done_next));
    $display("cyc=%0d v0=%0b v1=%0b cs=%0b win=%0d busy=%0b done=%0b", cyc, v0, v1, cs, win,
             clear_busy, clear_done);

    m_done_next = 1'b0;
    if (m_clear_left > 0) begin
      m_mem[caddr] = '0;
      m_clear_left--;
      if (m_clear_left == 0) m_done_next = 1'b1;
    end else if (cs) begin
      m_clear_left = MSZ;
    end else if (win >= 0) begin
      m_rr = win;
      if (ww) m_mem[wa] = wd;
      else if (win == 0) q0.push_back('{due: cyc + 1, data: m_mem[wa]});
      else q1.push_back('{due: cyc + 1, data: m_mem[wa]});
    end
    m_win = win;
  endtask

  task automatic idle();
    step(0, 0, 0, '0, 0, 0, 0, '0, 0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    clear_start = 1'b0;
    p0_valid = 1'b1; p0_we = 1'b1; p1_valid = 1'b1; p1_we = 1'b1;
    #1;
    chk("rst_busy", 64'(clear_busy), 64'(0));
    chk("rst_done", 64'(clear_done), 64'(0));
    chk("rst_wr_en", 64'(ram_wr_en), 64'(0));
    chk("rst_p0_ready", 64'(p0_ready), 64'(0));
    chk("rst_p1_ready", 64'(p1_ready), 64'(0));
    chk("rst_p0_rvalid", 64'(p0_rvalid), 64'(0));
    chk("rst_p1_rvalid", 64'(p1_rvalid), 64'(0));
    $display("reset asserted at cyc=%0d", cyc);
    m_clear_left = 0;
    m_done_next = 1'b0;
    m_rr = 1;
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    p0_valid = 1'b0; p1_valid = 1'b0; p0_we = 1'b0; p1_we = 1'b0;
    rst_n = 1'b1;
  endtask

  bit            pv [2];
  bit            pw [2];
  int            pa [2];
  logic [DW-1:0] pd [2];
  logic [63:0]   rnd;

  initial begin
    for (int i = 0; i < MSZ; i++) m_mem[i] = init_val(i);

    // Reset with requests asserted
    reset_pulse();

    // Single read of the known word
    step(1, 0, 5, '0, 0, 0, 0, '0, 0);
    idle();

    // Contention: both ports hold reads, grants must alternate
    repeat (4) step(1, 0, 1, '0, 1, 0, 2, '0, 0);
    idle();

    // Write then read back on P1
    step(0, 0, 0, '0, 1, 1, 7, 36'hABC, 0);
    step(0, 0, 0, '0, 1, 0, 7, '0, 0);
    idle();

    // Reset in the middle of a clear sweep
    step(0, 0, 0, '0, 0, 0, 0, '0, 1);
    while (m_clear_left != MSZ - 8) idle();
    reset_pulse();
    step(1, 0, 9, '0, 0, 0, 0, '0, 0);
    step(1, 0, 3, '0, 0, 0, 0, '0, 0);
    idle();

    // Full clear: P0 waits through it, a second clear_start is ignored
    step(1, 0, 4, '0, 0, 0, 0, '0, 1);
    for (int i = 0; i < MSZ; i++) step(1, 0, 4, '0, 0, 0, 0, '0, i == 5);
    step(1, 0, 4, '0, 0, 0, 0, '0, 0);
    step(1, 0, 0, '0, 1, 0, 15, '0, 0);
    step(1, 0, 9, '0, 0, 0, 0, '0, 0);
    idle();

    // Randomised traffic with held requests and occasional clears
    pv[0] = 1'b0; pv[1] = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && ($urandom % 3 != 0)) begin
          pv[p] = 1'b1;
          pw[p] = ($urandom % 2) == 1;
          pa[p] = int'($urandom % MSZ);
          rnd   = {$urandom, $urandom};
          pd[p] = rnd[DW-1:0];
        end
      end
      step(pv[0], pw[0], pa[0], pd[0], pv[1], pw[1], pa[1], pd[1], ($urandom % 150) == 0);
      if (m_win >= 0) pv[m_win] = 1'b0;
    end
    for (int i = 0; i < MSZ + 3; i++) idle();
    chk("p0_queue_drained", 64'(q0.size()), 64'(0));
    chk("p1_queue_drained", 64'(q1.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_sp_ram_arbiter
